// File: rtl/spinner_mc_if.sv
// spinner_mc_if: strobe, digital controls and analog samples into spinner_mc,
// angle and step outputs back out.
interface spinner_mc_if #(
  parameter int CHANNELS = 2,
  parameter int ANGLE_W  = 4
);
  logic                        strobe;
  logic [CHANNELS-1:0]         plus, minus, fast;
  logic [9*CHANNELS-1:0]       spin_in;
  logic [ANGLE_W*CHANNELS-1:0] spin_out;
  logic [CHANNELS-1:0]         step_pulse, step_dir;
  modport master (output strobe, plus, minus, fast, spin_in, input spin_out, step_pulse, step_dir);
  modport slave  (input strobe, plus, minus, fast, spin_in, output spin_out, step_pulse, step_dir);
endinterface

// File: rtl/spinner_mc.sv
// spinner_mc: multi-channel dial position tracker (wrapping spinner or clamping paddle).
// Define SPINNER_MC_DIR_EN to enable the step_pulse/step_dir outputs.
module spinner_mc #(
  parameter int                  CHANNELS    = 2,
  parameter int                  ANGLE_W     = 4,
  parameter int                  RATE        = 2,
  parameter int                  FRAC_W      = 2,
  parameter logic [CHANNELS-1:0] PADDLE_MASK = '0
) (
  input logic         clk,
  input logic         reset_n,
  spinner_mc_if.slave bus
);
  localparam int P_W = ANGLE_W + FRAC_W;
  // wide enough for position plus the largest combined analog+digital delta
  localparam int S_W = (P_W + 2 > 10) ? P_W + 2 : 10;
  localparam logic [3:0] THR_N = 4'(RATE);
  localparam logic [3:0] THR_F = ((RATE >> 1) > 0) ? 4'(RATE >> 1) : 4'd1;
  localparam logic [S_W-1:0] STEP = S_W'(1 << FRAC_W);
  logic strobe_q, init_q, edge_w;
  logic [ANGLE_W*CHANNELS-1:0] out_w;
  logic [CHANNELS-1:0] pulse_w, dir_w;
  assign edge_w = bus.strobe & ~strobe_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_q <= 1'b0;
      init_q   <= 1'b0;
    end else begin
      strobe_q <= bus.strobe;
      init_q   <= 1'b1;
    end
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [P_W-1:0] RST_POS = PADDLE_MASK[c] ? {1'b1, {(P_W-1){1'b0}}} : '0;
    logic [P_W-1:0] pos_q, pos_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] cnt_inc;
    logic tog_q, ana, dig, mv;
    logic [8:0] smp;
    logic [S_W-1:0] delta, sum;
    assign smp = bus.spin_in[c*9 +: 9];
    always_comb begin
      mv      = bus.plus[c] ^ bus.minus[c];
      cnt_inc = {1'b0, cnt_q} + 5'd1;
      dig     = edge_w & mv & (cnt_inc >= {1'b0, bus.fast[c] ? THR_F : THR_N});
      cnt_d   = !edge_w ? cnt_q : (!mv || dig) ? 4'd0 : cnt_inc[3:0];
      ana     = init_q & (smp[8] ^ tog_q);
      delta   = (ana ? {{(S_W-8){smp[7]}}, smp[7:0]} : '0) +
                (dig ? (bus.plus[c] ? STEP : -STEP) : '0);
      sum     = {{(S_W-P_W){1'b0}}, pos_q} + delta;
      pos_d   = !PADDLE_MASK[c] ? sum[P_W-1:0] :
                sum[S_W-1] ? '0 : (|sum[S_W-2:P_W]) ? '1 : sum[P_W-1:0];
    end
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pos_q <= RST_POS;
        cnt_q <= '0;
        tog_q <= 1'b0;
      end else begin
        pos_q <= pos_d;
        cnt_q <= cnt_d;
        tog_q <= smp[8];
      end
    end
    assign out_w[c*ANGLE_W +: ANGLE_W] = pos_q[P_W-1:FRAC_W];
`ifdef SPINNER_MC_DIR_EN
    logic pulse_q, dir_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        pulse_q <= 1'b0;
        dir_q   <= 1'b0;
      end else begin
        pulse_q <= |delta;
        if (|delta) dir_q <= ~delta[S_W-1];
      end
    end
    assign pulse_w[c] = pulse_q;
    assign dir_w[c]   = dir_q;
`else
    assign pulse_w[c] = 1'b0;
    assign dir_w[c]   = 1'b0;
`endif
  end
  assign bus.spin_out   = out_w;
  assign bus.step_pulse = pulse_w;
  assign bus.step_dir   = dir_w;
endmodule
